// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default datapath width, result-beat payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ALU_ADD/ALU_SUB/ALU_AND/ALU_OR : ALUControl encodings
//   ALU_DATA_W                     : default result width
//   alu_res_t                      : {result, zero, cout, ctrl} beat payload
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  cout;
    logic [1:0]            ctrl;
  } alu_res_t;

  // Arithmetic ops are the only ones whose carry-out is meaningful.
  function automatic logic is_arith(input logic [1:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main register + skid register).
// Latency: 1 cycle from accept to out_vld when empty; 1 beat/cycle sustained.
// Backpressure: in_rdy is a registered !skid_full, no comb path from out_rdy.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_vld/in_rdy/in_dat  : upstream handshake and payload
//   out_vld/out_rdy/out_dat : downstream handshake and payload (from main reg)
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int W = $bits(alu_res_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         main_vld, main_vld_nxt;
  logic [W-1:0] main_dat, main_dat_nxt;
  logic         skid_vld, skid_vld_nxt;
  logic [W-1:0] skid_dat, skid_dat_nxt;
  logic         in_rdy_q;

  logic accept;
  logic retire;
  logic main_load;

  assign accept    = in_vld && in_rdy_q;
  assign retire    = main_vld && out_rdy;
  // Main register is free to take a new beat when empty or draining this cycle.
  assign main_load = !main_vld || retire;

  always_comb begin
    main_vld_nxt = main_vld;
    main_dat_nxt = main_dat;
    skid_vld_nxt = skid_vld;
    skid_dat_nxt = skid_dat;
    if (main_load) begin
      if (skid_vld) begin
        // Skid entry is older than anything at the input; it goes first.
        // No accept can coincide here since in_rdy is low while skid is full.
        main_vld_nxt = 1'b1;
        main_dat_nxt = skid_dat;
        skid_vld_nxt = 1'b0;
      end else if (accept) begin
        main_vld_nxt = 1'b1;
        main_dat_nxt = in_dat;
      end else begin
        main_vld_nxt = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the beat in the skid register.
      skid_vld_nxt = 1'b1;
      skid_dat_nxt = in_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      main_vld <= main_vld_nxt;
      main_dat <= main_dat_nxt;
      skid_vld <= skid_vld_nxt;
      skid_dat <= skid_dat_nxt;
      // Dedicated flop so in_rdy has no logic between register and port.
      in_rdy_q <= !skid_vld_nxt;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = main_vld;
  assign out_dat = main_dat;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with skid buffering, sticky zero/carry flags and retire counter.
// Latency: 1 cycle from accepted beat to out_valid when empty; full throughput.
// Backpressure: in_ready drops only when both buffer entries are occupied.
//
// Ports:
//   clk, rst_n                                   : clock, async active-low reset
//   in_valid/in_ready, in_result/zero/cout/ctrl  : ALU output beat
//   out_valid/out_ready, out_result/zero/cout/ctrl : registered beat to writeback
//   clr_flags                                    : sync clear of sticky flags and op_count
//   sticky_zero, sticky_carry, op_count          : status for software/debug
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_cout,
  input  logic [1:0]        in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_cout,
  output logic [1:0]        out_ctrl,
  input  logic              clr_flags,
  output logic              sticky_zero,
  output logic              sticky_carry,
  output logic [CNT_W-1:0]  op_count
);

  // Payload layout mirrors alu_res_t but follows this instance's DATA_W.
  localparam int PW = DATA_W + 4;

  logic [PW-1:0] buf_in_dat;
  logic [PW-1:0] buf_out_dat;

  assign buf_in_dat = {in_result, in_zero, in_cout, in_ctrl};

  alu_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (buf_in_dat),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (buf_out_dat)
  );

  assign out_result = buf_out_dat[PW-1:4];
  assign out_zero   = buf_out_dat[3];
  assign out_cout   = buf_out_dat[2];
  assign out_ctrl   = buf_out_dat[1:0];

  logic accept;
  logic retire;
  logic set_zero;
  logic set_carry;

  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign set_zero  = accept && in_zero;
  // AND/OR carry-out is meaningless, so only arithmetic beats count.
  assign set_carry = accept && in_cout && is_arith(in_ctrl);

  // Priority: a set event beats a same-cycle clear, and a same-cycle
  // retire is counted after the clear (count restarts at 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_zero  <= 1'b0;
      sticky_carry <= 1'b0;
      op_count     <= '0;
    end else begin
      if (set_zero)
        sticky_zero <= 1'b1;
      else if (clr_flags)
        sticky_zero <= 1'b0;

      if (set_carry)
        sticky_carry <= 1'b1;
      else if (clr_flags)
        sticky_carry <= 1'b0;

      if (clr_flags)
        op_count <= retire ? CNT_W'(1) : '0;
      else if (retire)
        op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic              in_cout;
  logic [1:0]        in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_cout;
  logic [1:0]        out_ctrl;
  logic              clr_flags;
  logic              sticky_zero;
  logic              sticky_carry;
  logic [CNT_W-1:0]  op_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a FIFO of at most two beats plus flag/counter state.
  logic [DATA_W+3:0] mq[$];
  logic              m_sz;
  logic              m_sc;
  logic [CNT_W-1:0]  m_cnt;

  always #5 clk = ~clk;

  alu_result_stage #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_cout      (in_cout),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_cout     (out_cout),
    .out_ctrl     (out_ctrl),
    .clr_flags    (clr_flags),
    .sticky_zero  (sticky_zero),
    .sticky_carry (sticky_carry),
    .op_count     (op_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sz  = 1'b0;
    m_sc  = 1'b0;
    m_cnt = '0;
  endtask

  // Compare DUT to model at the falling edge, then advance the model by the
  // handshakes that happen on the next rising edge. Returns at posedge+1.
  task automatic cycle();
    bit acc, ret;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0)
      chk("out_payload", 64'({out_result, out_zero, out_cout, out_ctrl}), 64'(mq[0]));
    chk("sticky_zero", 64'(sticky_zero), 64'(m_sz));
    chk("sticky_carry", 64'(sticky_carry), 64'(m_sc));
    chk("op_count", 64'(op_count), 64'(m_cnt));
    acc = in_valid && (mq.size() < 2);
    ret = out_ready && (mq.size() > 0);
    if (clr_flags) begin
      m_sz  = 1'b0;
      m_sc  = 1'b0;
      m_cnt = '0;
    end
    if (acc && in_zero) m_sz = 1'b1;
    if (acc && in_cout && (in_ctrl == 2'b00 || in_ctrl == 2'b01)) m_sc = 1'b1;
    if (ret) begin
      m_cnt = m_cnt + 1'b1;
      void'(mq.pop_front());
    end
    if (acc) mq.push_back({in_result, in_zero, in_cout, in_ctrl});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] r, input logic z, input logic c,
                            input logic [1:0] op);
    in_valid  = 1'b1;
    in_result = r;
    in_zero   = z;
    in_cout   = c;
    in_ctrl   = op;
  endtask

  initial begin
    // Reset with random inputs toggling.
    rst_n     = 1'b0;
    clr_flags = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_result = $urandom;
      in_zero   = 1'($urandom);
      in_cout   = 1'($urandom);
      in_ctrl   = 2'($urandom);
      out_ready = 1'($urandom);
      clr_flags = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_sticky_zero", 64'(sticky_zero), 64'd0);
      chk("rst_sticky_carry", 64'(sticky_carry), 64'd0);
      chk("rst_out_result", 64'(out_result), 64'd0);
    end
    in_valid  = 1'b0;
    clr_flags = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single beat.
    drive_beat(32'h5, 1'b0, 1'b0, 2'b00);
    cycle();
    in_valid = 1'b0;
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_out_result", 64'(out_result), 64'h5);
    cycle();
    chk("single_op_count", 64'(op_count), 64'd1);

    // Backpressure: 0x11, 0x22 accepted, 0x33 held.
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    out_ready = 1'b0;
    drive_beat(32'h11, 1'b0, 1'b0, 2'b00);
    cycle();
    drive_beat(32'h22, 1'b0, 1'b0, 2'b00);
    cycle();
    drive_beat(32'h33, 1'b0, 1'b0, 2'b00);
    cycle();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_held", 64'(out_result), 64'h11);
    cycle();
    out_ready = 1'b1;
    cycle();
    chk("bp_second", 64'(out_result), 64'h22);
    cycle();
    in_valid = 1'b0;
    chk("bp_third", 64'(out_result), 64'h33);
    cycle();
    chk("bp_op_count", 64'(op_count), 64'd3);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flags: SUB with zero and carry.
    drive_beat(32'h0, 1'b1, 1'b1, 2'b01);
    cycle();
    in_valid = 1'b0;
    chk("flag_sz_set", 64'(sticky_zero), 64'd1);
    chk("flag_sc_set", 64'(sticky_carry), 64'd1);
    cycle();
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    drive_beat(32'hFFFF_0000, 1'b0, 1'b1, 2'b10);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("flag_and_no_carry", 64'(sticky_carry), 64'd0);

    // Clear collision: retire + accept zero beat + clear in one cycle.
    out_ready = 1'b0;
    drive_beat(32'hA5A5_0001, 1'b0, 1'b0, 2'b11);
    cycle();
    out_ready = 1'b1;
    clr_flags = 1'b1;
    drive_beat(32'h0, 1'b1, 1'b0, 2'b10);
    cycle();
    clr_flags = 1'b0;
    in_valid  = 1'b0;
    chk("coll_sticky_zero", 64'(sticky_zero), 64'd1);
    chk("coll_op_count", 64'(op_count), 64'd1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_result = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      in_zero   = (in_result == 32'h0);
      in_cout   = ($urandom_range(0, 5) == 0);
      in_ctrl   = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_flags = ($urandom_range(0, 19) == 0);
      cycle();
    end
    clr_flags = 1'b0;

    // Async reset mid-stall with two beats buffered.
    out_ready = 1'b0;
    drive_beat(32'hDEAD_0001, 1'b0, 1'b0, 2'b00);
    cycle();
    drive_beat(32'hDEAD_0002, 1'b0, 1'b0, 2'b00);
    cycle();
    in_valid = 1'b0;
    chk("ar_full_before", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_op_count", 64'(op_count), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("ar_no_stale", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
